// File: rtl/cm0_dap_cdc_recv_data.sv
// Receive-side controller for a 32-bit four-phase REQ/ACK crossing: REQ synchroniser, AND-mask enable,
// data capture, ACK return and a one-entry valid/ready buffer. CM0_DAP_CDC_SYNC3_EN selects a 3-flop REQ synchroniser.
module cm0_dap_cdc_recv_data #(
  parameter int PRESENT         = 1,
  parameter int SYNC_STAGES_MIN = 2
) (
  input  logic        DCLK,
  input  logic        DBGRESET,
  input  logic        REQ_ASYNC,
  output logic        MASKN,
  input  logic [31:0] MASKED_DATA,
  output logic        ACK,
  output logic [31:0] RDATA,
  output logic        RVALID,
  input  logic        RREADY
);

`ifdef CM0_DAP_CDC_SYNC3_EN
  localparam int SYNC_REQ = 3;
`else
  localparam int SYNC_REQ = 2;
`endif
  // Depth never drops below the documented minimum.
  localparam int SYNC_STAGES = (SYNC_REQ > SYNC_STAGES_MIN) ? SYNC_REQ : SYNC_STAGES_MIN;

  generate
    if (PRESENT != 0) begin : g_present
      // state | meaning
      // IDLE  | mask closed, waiting for a fresh req_s with the buffer free
      // OPEN  | mask open, data settling, not sampled
      // CAPT  | mask open, word captured at the end of this cycle
      // HOLD  | mask closed, ACK high, waiting for req_s to fall
      typedef enum logic [1:0] {IDLE, OPEN, CAPT, HOLD} state_t;

      state_t                 state_q, state_d;
      logic [SYNC_STAGES-1:0] req_sync_q;
      logic                   req_s;
      logic                   edge_blk_q;
      logic                   maskn_q, maskn_d;
      logic                   ack_q, ack_d;
      logic                   rvalid_q;
      logic [31:0]            rdata_q;
      logic                   buf_free;
      logic                   capt;

      assign req_s    = req_sync_q[SYNC_STAGES-1];
      assign buf_free = !rvalid_q || RREADY;
      assign capt     = (state_q == CAPT);

      always_comb begin
        state_d = state_q;
        case (state_q)
          IDLE:    if (req_s && !edge_blk_q && buf_free) state_d = OPEN;
          OPEN:    state_d = CAPT;
          CAPT:    state_d = HOLD;
          HOLD:    if (!req_s) state_d = IDLE;
          default: state_d = IDLE;
        endcase
        maskn_d = (state_d == OPEN) || (state_d == CAPT);
        ack_d   = (state_d == HOLD);
      end

      always_ff @(posedge DCLK) begin
        if (DBGRESET) begin
          req_sync_q <= '0;
          state_q    <= IDLE;
          edge_blk_q <= 1'b0;
          maskn_q    <= 1'b0;
          ack_q      <= 1'b0;
          rvalid_q   <= 1'b0;
          rdata_q    <= '0;
        end else begin
          req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], REQ_ASYNC};
          state_q    <= state_d;
          maskn_q    <= maskn_d;
          ack_q      <= ack_d;
          // A transfer needs req_s to be seen low before the next one may start.
          if (!req_s)
            edge_blk_q <= 1'b0;
          else if (state_q == HOLD)
            edge_blk_q <= 1'b1;
          if (capt)
            rvalid_q <= 1'b1;
          else if (rvalid_q && RREADY)
            rvalid_q <= 1'b0;
          if (capt)
            rdata_q <= MASKED_DATA;
        end
      end

      assign MASKN  = maskn_q;
      assign ACK    = ack_q;
      assign RVALID = rvalid_q;
      assign RDATA  = rdata_q;
    end else begin : g_absent
      assign MASKN  = 1'b0;
      assign ACK    = 1'b0;
      assign RVALID = 1'b0;
      assign RDATA  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_cm0_dap_cdc_recv_data.sv
// Bench for cm0_dap_cdc_recv_data: transaction-level model checked every cycle plus directed literal checks.
module tb_cm0_dap_cdc_recv_data;

`ifdef CM0_DAP_CDC_SYNC3_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        DCLK;
  logic        DBGRESET;
  logic        REQ_ASYNC;
  logic        MASKN;
  logic [31:0] MASKED_DATA;
  logic        ACK;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] word;

  int checks = 0;
  int errors = 0;

  cm0_dap_cdc_recv_data dut (
    .DCLK        (DCLK),
    .DBGRESET    (DBGRESET),
    .REQ_ASYNC   (REQ_ASYNC),
    .MASKN       (MASKN),
    .MASKED_DATA (MASKED_DATA),
    .ACK         (ACK),
    .RDATA       (RDATA),
    .RVALID      (RVALID),
    .RREADY      (RREADY)
  );

  // The AND-mask stage in front of the receiver.
  assign MASKED_DATA = MASKN ? word : 32'h0;

  initial DCLK = 1'b0;
  always #5 DCLK = ~DCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: REQ delay line, transfer age (-1 idle, 0 open, 1 capture, 2 holding ACK), word queue.
  logic [LAT-1:0] hist;
  int             age = -1;
  bit             blocked;
  logic [31:0]    mq[$];
  logic [31:0]    rdata_m;
  bit             armed = 0;

  always @(posedge DCLK) begin
    bit rs_m, free, pop, capt_m;
    int nage;
    rs_m = hist[LAT-1];
    if (DBGRESET) begin
      hist    = '0;
      age     = -1;
      blocked = 0;
      mq.delete();
      rdata_m = 32'h0;
      armed   = 1;
    end else begin
      free   = (mq.size() == 0) || RREADY;
      pop    = (mq.size() != 0) && RREADY;
      capt_m = (age == 1);
      if (age < 0)      nage = (rs_m && !blocked && free) ? 0 : -1;
      else if (age < 2) nage = age + 1;
      else              nage = rs_m ? 2 : -1;
      if (!rs_m)         blocked = 0;
      else if (age >= 2) blocked = 1;
      if (pop && !capt_m) void'(mq.pop_front());
      if (capt_m) begin
        mq.delete();
        mq.push_back(word);
        rdata_m = word;
      end
      age  = nage;
      hist = {hist[LAT-2:0], REQ_ASYNC};
    end
  end

  int   maskn_cycles = 0;
  int   ack_cycles   = 0;
  int   rvalid_rises = 0;
  logic rvalid_prev  = 1'b0;

  always @(negedge DCLK) begin
    if (armed) begin
      chk("maskn", {31'h0, MASKN}, {31'h0, (age == 0) || (age == 1)});
      chk("ack", {31'h0, ACK}, {31'h0, age == 2});
      chk("rvalid", {31'h0, RVALID}, {31'h0, mq.size() != 0});
      chk("rdata", RDATA, rdata_m);
      if (MASKN === 1'b1) maskn_cycles++;
      if (ACK === 1'b1) ack_cycles++;
      if (RVALID === 1'b1 && rvalid_prev !== 1'b1) rvalid_rises++;
      rvalid_prev = RVALID;
    end
  end

  task automatic step();
    @(negedge DCLK);
    #1;
  endtask

  function automatic logic cur(input int which);
    case (which)
      0:       return MASKN;
      1:       return ACK;
      default: return RVALID;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input logic val, input int max, output int n);
    n = 0;
    while (n < max && cur(which) !== val) begin
      step();
      n++;
    end
    if (cur(which) !== val) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles waiting for %b", name, max, val);
    end
  endtask

  int n1, n2, s_mask, s_ack, s_rise;

  initial begin
    DBGRESET  = 1'b1;
    REQ_ASYNC = 1'b0;
    RREADY    = 1'b0;
    word      = 32'h0;
    repeat (3) step();
    DBGRESET = 1'b0;
    chk("reset_maskn", {31'h0, MASKN}, 32'h0);
    chk("reset_ack", {31'h0, ACK}, 32'h0);
    chk("reset_rvalid", {31'h0, RVALID}, 32'h0);
    chk("reset_rdata", RDATA, 32'h0);
    step();

    // Basic transfer with a ready consumer.
    RREADY = 1'b1;
    word   = 32'hDEADBEEF;
    s_mask = maskn_cycles;
    REQ_ASYNC = 1'b1;
    wait_sig("s1_maskn_rise", 0, 1'b1, 10, n1);
    chk("s1_maskn_latency", n1, LAT + 1);
    wait_sig("s1_ack_rise", 1, 1'b1, 10, n2);
    chk("s1_ack_latency", n1 + n2, LAT + 3);
    chk("s1_rdata", RDATA, 32'hDEADBEEF);
    chk("s1_rvalid", {31'h0, RVALID}, 32'h1);
    step();
    chk("s1_rvalid_clear", {31'h0, RVALID}, 32'h0);
    chk("s1_maskn_cycles", maskn_cycles - s_mask, 2);
    REQ_ASYNC = 1'b0;
    wait_sig("s1_ack_fall", 1, 1'b0, LAT + 1, n1);
    step();

    // Back-pressure: second request stalls while the first word is unconsumed.
    RREADY = 1'b0;
    word   = 32'h1;
    REQ_ASYNC = 1'b1;
    wait_sig("s2_ack1", 1, 1'b1, 10, n1);
    REQ_ASYNC = 1'b0;
    wait_sig("s2_ack1_fall", 1, 1'b0, 10, n1);
    word = 32'h2;
    REQ_ASYNC = 1'b1;
    repeat (10) step();
    chk("s2_stall_maskn", {31'h0, MASKN}, 32'h0);
    chk("s2_stall_ack", {31'h0, ACK}, 32'h0);
    chk("s2_held_rvalid", {31'h0, RVALID}, 32'h1);
    chk("s2_held_rdata", RDATA, 32'h1);
    RREADY = 1'b1;
    wait_sig("s2_ack2", 1, 1'b1, 10, n1);
    chk("s2_rdata2", RDATA, 32'h2);
    REQ_ASYNC = 1'b0;
    wait_sig("s2_ack2_fall", 1, 1'b0, 10, n1);
    step();

    // Early REQ drop during OPEN.
    RREADY = 1'b0;
    word   = 32'h3C3C0F0F;
    s_ack  = ack_cycles;
    REQ_ASYNC = 1'b1;
    wait_sig("s3_maskn", 0, 1'b1, 10, n1);
    REQ_ASYNC = 1'b0;
    repeat (8) step();
    chk("s3_ack_pulse", ack_cycles - s_ack, 1);
    chk("s3_rvalid", {31'h0, RVALID}, 32'h1);
    chk("s3_rdata", RDATA, 32'h3C3C0F0F);
    RREADY = 1'b1;
    step();
    RREADY = 1'b0;
    step();

    // REQ held high long after ACK: exactly one capture.
    RREADY = 1'b1;
    word   = 32'h0BADF00D;
    s_mask = maskn_cycles;
    s_rise = rvalid_rises;
    REQ_ASYNC = 1'b1;
    wait_sig("s4_ack", 1, 1'b1, 10, n1);
    repeat (20) step();
    chk("s4_maskn_cycles", maskn_cycles - s_mask, 2);
    chk("s4_captures", rvalid_rises - s_rise, 1);
    chk("s4_maskn_low", {31'h0, MASKN}, 32'h0);
    chk("s4_ack_high", {31'h0, ACK}, 32'h1);
    REQ_ASYNC = 1'b0;
    wait_sig("s4_ack_fall", 1, 1'b0, 10, n1);
    step();

    // Reset during CAPT, then a fresh transfer.
    RREADY = 1'b0;
    word   = 32'h12345678;
    REQ_ASYNC = 1'b1;
    wait_sig("s5_maskn", 0, 1'b1, 10, n1);
    step();
    chk("s5_in_capt", {31'h0, MASKN}, 32'h1);
    DBGRESET  = 1'b1;
    REQ_ASYNC = 1'b0;
    step();
    chk("s5_rst_maskn", {31'h0, MASKN}, 32'h0);
    chk("s5_rst_ack", {31'h0, ACK}, 32'h0);
    chk("s5_rst_rvalid", {31'h0, RVALID}, 32'h0);
    chk("s5_rst_rdata", RDATA, 32'h0);
    DBGRESET = 1'b0;
    repeat (2) step();
    word = 32'hA5A5A5A5;
    REQ_ASYNC = 1'b1;
    wait_sig("s5_ack", 1, 1'b1, 10, n1);
    chk("s5_rdata", RDATA, 32'hA5A5A5A5);
    chk("s5_rvalid", {31'h0, RVALID}, 32'h1);
    REQ_ASYNC = 1'b0;
    wait_sig("s5_ack_fall", 1, 1'b0, 10, n1);
    RREADY = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
